// File: rtl/lcd_text_fetch.sv
// Character BRAM sequencer for the LCD driver: streams a string from BRAM over valid/ready,
// inserting DDRAM line-address commands at line boundaries and stopping early on a terminator.
module lcd_text_fetch #(
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned LEN_W      = 6,
   parameter int unsigned LINE_CHARS = 16,
   parameter logic [7:0]  LINE2_CMD  = 8'hC0,
   parameter logic [7:0]  LINE1_CMD  = 8'h80,
   parameter bit          TERM_EN    = 1'b1,
   parameter logic [7:0]  TERM_CHAR  = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [7:0]        bram_data,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic              out_is_cmd,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LC_W = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_SEND, S_CMD, S_FIN
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  remaining;
   logic [LC_W-1:0]   line_cnt;
   logic              line_sel;

   // Single-process sequencer; every output is a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         remaining  <= '0;
         line_cnt   <= '0;
         line_sel   <= 1'b0;
         bram_addr  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_is_cmd <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ptr       <= base_addr;
                  remaining <= length;
                  line_cnt  <= '0;
                  line_sel  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (length == '0) ? S_FIN : S_ADDR;
               end
            end
            S_ADDR: begin
               bram_addr <= ptr;
               state     <= S_WAIT;
            end
            // BRAM registers the address on this edge; data appears next cycle.
            S_WAIT: state <= S_LATCH;
            S_LATCH: begin
               if (TERM_EN && (bram_data == TERM_CHAR)) begin
                  state <= S_FIN;
               end else begin
                  out_data   <= bram_data;
                  out_is_cmd <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= S_SEND;
               end
            end
            S_SEND: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  ptr       <= ptr + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state <= S_FIN;
                  end else if (line_cnt == LC_W'(LINE_CHARS - 1)) begin
                     line_cnt <= '0;
                     state    <= S_CMD;
                  end else begin
                     line_cnt <= line_cnt + LC_W'(1);
                     state    <= S_ADDR;
                  end
               end
            end
            // First cycle loads the command byte; then hold until accepted.
            S_CMD: begin
               if (!out_valid) begin
                  out_data   <= line_sel ? LINE1_CMD : LINE2_CMD;
                  out_is_cmd <= 1'b1;
                  out_valid  <= 1'b1;
               end else if (out_ready) begin
                  line_sel  <= ~line_sel;
                  out_valid <= 1'b0;
                  state     <= S_ADDR;
               end
            end
            S_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_fetch.sv
// Scoreboard bench for lcd_text_fetch: a BRAM model feeds the DUT, a string model predicts
// the byte/command stream, and a per-cycle monitor pops and checks each accepted byte.
module tb_lcd_text_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [5:0]  length;
   logic [10:0] bram_addr;
   logic [7:0]  bram_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_is_cmd;
   logic        out_ready;
   logic        busy;
   logic        done;

   lcd_text_fetch dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .bram_addr(bram_addr), .bram_data(bram_data), .out_valid(out_valid), .out_data(out_data),
      .out_is_cmd(out_is_cmd), .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:2047];
   always @(posedge clk) bram_data <= mem[bram_addr];

   logic [8:0] sb[$];
   int checks = 0;
   int errors = 0;
   int ready_mode = 0;   // 0: always ready, 1: ready 30% of cycles, 2: never ready
   int done_cnt = 0;
   int hs_cnt = 0;
   logic       hold_pend = 1'b0;
   logic [7:0] hold_data;
   logic       hold_cmd;

   // One cycle: pick ready for the next edge, then check the stream as it stands now.
   task automatic tick();
      logic [8:0] exp;
      @(negedge clk);
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 99) < 30);
         default: out_ready = 1'b0;
      endcase
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            checks++;
            if (!out_valid || out_data !== hold_data || out_is_cmd !== hold_cmd) begin
               errors++;
               $display("FAIL hold_stable: got v=%b d=%h c=%b want v=1 d=%h c=%b",
                        out_valid, out_data, out_is_cmd, hold_data, hold_cmd);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            hs_cnt++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got d=%h c=%b want none", out_data, out_is_cmd);
            end else begin
               exp = sb.pop_front();
               if ({out_is_cmd, out_data} !== exp) begin
                  errors++;
                  $display("FAIL stream_byte: got c=%b d=%h want c=%b d=%h",
                           out_is_cmd, out_data, exp[8], exp[7:0]);
               end
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_data = out_data;
         hold_cmd  = out_is_cmd;
         if (done) done_cnt++;
      end
   endtask

   // Expected stream for a fetch, walked over the BRAM image.
   task automatic push_expected(input logic [10:0] base, input int len);
      logic [10:0] a;
      logic        sel;
      a   = base;
      sel = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (mem[a] == 8'hFF) break;
         sb.push_back({1'b0, mem[a]});
         if (i != len - 1 && (i % 16) == 15) begin
            sb.push_back({1'b1, sel ? 8'h80 : 8'hC0});
            sel = ~sel;
         end
         a = a + 11'd1;
      end
   endtask

   task automatic start_fetch(input logic [10:0] base, input logic [5:0] len);
      tick();
      start     = 1'b1;
      base_addr = base;
      length    = len;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done_timeout: got no done want done", name);
      end
   endtask

   task automatic check_drained(input string name, input int exp_hs, input int hs0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: got %0d left want 0", name, sb.size());
      end
      checks++;
      if (hs_cnt - hs0 != exp_hs) begin
         errors++;
         $display("FAIL %s_handshakes: got %0d want %0d", name, hs_cnt - hs0, exp_hs);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({bram_addr, out_valid, out_data, out_is_cmd, busy, done} !== 23'd0) begin
         errors++;
         $display("FAIL reset_values: got addr=%h v=%b d=%h c=%b busy=%b done=%b want all 0",
                  bram_addr, out_valid, out_data, out_is_cmd, busy, done);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int hs0, d0;
      hs0 = hs_cnt;
      d0  = done_cnt;
      ready_mode = 0;
      push_expected(11'h000, 5);
      start_fetch(11'h000, 6'd5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b want 1", busy);
      end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (out_valid !== (k == 4)) begin
            errors++;
            $display("FAIL basic_latency: cycle %0d got valid=%b want %b", k, out_valid, k == 4);
         end
         if (k < 4) tick();
      end
      wait_done("basic");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_end: got %b want 0", busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%b pulses=%0d want 0 and 1", done, done_cnt - d0);
      end
      check_drained("basic", 5, hs0);
   endtask

   task automatic test_line_wrap();
      int hs0;
      hs0 = hs_cnt;
      ready_mode = 0;
      push_expected(11'h000, 20);
      start_fetch(11'h000, 6'd20);
      wait_done("line_wrap");
      tick();
      check_drained("line_wrap", 21, hs0);
   endtask

   task automatic test_terminator();
      int hs0;
      hs0 = hs_cnt;
      ready_mode = 0;
      push_expected(11'h020, 31);
      start_fetch(11'h020, 6'd31);
      wait_done("term");
      tick();
      check_drained("term", 15, hs0);
   endtask

   task automatic test_zero_len_and_ignore();
      int hs0;
      hs0 = hs_cnt;
      start_fetch(11'h000, 6'd0);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_len_c1: got done=%b busy=%b want 0 1", done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_done: got done=%b busy=%b want 1 0", done, busy);
      end
      tick();
      check_drained("zero_len", 0, hs0);
      hs0 = hs_cnt;
      push_expected(11'h005, 7);
      start_fetch(11'h005, 6'd7);
      repeat (3) tick();
      start     = 1'b1;
      base_addr = 11'h100;
      length    = 6'd40;
      tick();
      start = 1'b0;
      wait_done("ignore");
      repeat (8) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_busy: got %b want 0", busy);
      end
      check_drained("ignore", 7, hs0);
   endtask

   task automatic test_addr_wrap_backpressure();
      int hs0;
      hs0 = hs_cnt;
      ready_mode = 1;
      push_expected(11'h7FE, 3);
      start_fetch(11'h7FE, 6'd3);
      wait_done("wrap");
      tick();
      check_drained("wrap", 3, hs0);
      ready_mode = 1;
      hs0 = hs_cnt;
      push_expected(11'h000, 20);
      start_fetch(11'h000, 6'd20);
      wait_done("bp_line");
      tick();
      check_drained("bp_line", 21, hs0);
      ready_mode = 0;
   endtask

   task automatic test_reset_mid_send();
      int  d0, hs0;
      bit  seen;
      ready_mode = 2;
      start_fetch(11'h000, 6'd10);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midreset_valid_timeout: got no valid want valid");
      end
      tick();
      d0 = done_cnt;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: got v=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
      end
      repeat (10) tick();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
      end
      ready_mode = 0;
      hs0 = hs_cnt;
      push_expected(11'h000, 5);
      start_fetch(11'h000, 6'd5);
      wait_done("restart");
      tick();
      check_drained("restart", 5, hs0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h20;
      for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);
      for (int i = 0; i < 15; i++) mem[32 + i] = 8'h61 + 8'(i);
      mem[11'h02F] = 8'hFF;
      mem[11'h7FE] = 8'hA1;
      mem[11'h7FF] = 8'hA2;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_line_wrap();
      test_terminator();
      test_zero_len_and_ignore();
      test_addr_wrap_backpressure();
      test_reset_mid_send();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
